// File: rtl/vram_arbiter.sv
// Sequencer for the single-port video SRAM. Scanout fetch has strict priority
// over MCU writes, which have priority over refreshing the cached MCU read-back byte.
module vram_arbiter #(
  parameter int ADDR_WIDTH         = 17,
  parameter int DATA_WIDTH         = 8,
  parameter int READ_WAIT_STATES   = 1,
  parameter int WRITE_PULSE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  videoReadRequest,
  input  logic [ADDR_WIDTH-1:0] videoReadAddress,
  output logic [DATA_WIDTH-1:0] videoReadData,
  output logic                  videoReadValid,
  output logic                  videoOverrun,
  input  logic                  memoryWriteRequest,
  input  logic [ADDR_WIDTH-1:0] memoryWriteAddress,
  input  logic [DATA_WIDTH-1:0] memoryWriteData,
  output logic                  memoryWriteComplete,
  input  logic [ADDR_WIDTH-1:0] memoryReadAddress,
  output logic [DATA_WIDTH-1:0] memoryReadData,
  output logic [ADDR_WIDTH-1:0] sramAddress,
  output logic [DATA_WIDTH-1:0] sramDataOut,
  output logic                  sramDataOutEnable,
  input  logic [DATA_WIDTH-1:0] sramDataIn,
  output logic                  sramChipEnableN,
  output logic                  sramOutputEnableN,
  output logic                  sramWriteEnableN
);

  // Handshakes: videoReadRequest is a one-cycle fire-and-forget pulse answered by
  // one videoReadValid pulse; memoryWriteRequest is a level held (with stable
  // address/data) until the memoryWriteComplete pulse, then dropped by the requester.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VREAD  = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4,
    RREAD  = 3'd5
  } state_t;

  localparam logic [1:0] READ_LAST  = READ_WAIT_STATES[1:0];
  localparam logic [1:0] PULSE_LAST = 2'(WRITE_PULSE_CYCLES - 1);

  state_t                  state;
  state_t                  nextState;
  logic [1:0]              phaseCount;
  logic                    pendingValid;
  logic [ADDR_WIDTH-1:0]   pendingAddress;
  logic [ADDR_WIDTH-1:0]   operationAddress;
  logic [DATA_WIDTH-1:0]   writeDataReg;
  logic [ADDR_WIDTH-1:0]   cacheAddress;
  logic                    staleFlag;
  logic                    cooldown;
  logic                    readStale;
  logic                    startVideo;
  logic                    startWrite;
  logic                    startRead;

  assign readStale  = staleFlag || (memoryReadAddress != cacheAddress);
  assign startVideo = (state == IDLE) && (nextState == VREAD);
  assign startWrite = (state == IDLE) && (nextState == WSETUP);
  assign startRead  = (state == IDLE) && (nextState == RREAD);

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (pendingValid)                           nextState = VREAD;
        else if (memoryWriteRequest && !cooldown)   nextState = WSETUP;
        else if (readStale)                         nextState = RREAD;
      end
      VREAD, RREAD: if (phaseCount == READ_LAST)    nextState = IDLE;
      WSETUP:                                       nextState = WPULSE;
      WPULSE: if (phaseCount == PULSE_LAST)         nextState = WHOLD;
      WHOLD:                                        nextState = IDLE;
      default:                                      nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state            <= IDLE;
      phaseCount       <= '0;
      pendingValid     <= 1'b0;
      pendingAddress   <= '0;
      operationAddress <= '0;
      writeDataReg     <= '0;
      cacheAddress     <= '0;
      staleFlag        <= 1'b1;
      cooldown         <= 1'b0;
      videoReadData    <= '0;
      videoReadValid   <= 1'b0;
      videoOverrun     <= 1'b0;
      memoryReadData   <= '0;
    end else begin
      state          <= nextState;
      cooldown       <= (state == WHOLD);
      videoReadValid <= 1'b0;
      videoOverrun   <= videoReadRequest && pendingValid;

      if (state == IDLE || nextState != state) phaseCount <= '0;
      else                                      phaseCount <= phaseCount + 2'd1;

      if (videoReadRequest) pendingAddress <= videoReadAddress;
      // A request landing on the edge that launches the fetch is merged into it.
      if (startVideo) begin
        operationAddress <= videoReadRequest ? videoReadAddress : pendingAddress;
        pendingValid     <= 1'b0;
      end else if (videoReadRequest) begin
        pendingValid <= 1'b1;
      end

      if (startWrite) begin
        operationAddress <= memoryWriteAddress;
        writeDataReg     <= memoryWriteData;
      end

      if (startRead) begin
        operationAddress <= memoryReadAddress;
        cacheAddress     <= memoryReadAddress;
        staleFlag        <= 1'b0;
      end

      if (state == WHOLD && operationAddress == cacheAddress) staleFlag <= 1'b1;

      if (state == VREAD && phaseCount == READ_LAST) begin
        videoReadData  <= sramDataIn;
        videoReadValid <= 1'b1;
      end
      if (state == RREAD && phaseCount == READ_LAST) memoryReadData <= sramDataIn;
    end
  end

  assign sramAddress         = operationAddress;
  assign sramDataOut         = writeDataReg;
  assign sramDataOutEnable   = (state == WSETUP) || (state == WPULSE) || (state == WHOLD);
  assign sramChipEnableN     = (state == IDLE);
  assign sramOutputEnableN   = !((state == VREAD) || (state == RREAD));
  assign sramWriteEnableN    = (state != WPULSE);
  assign memoryWriteComplete = (state == WHOLD);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: SRAM pin model, reference memory, video
// expectation queue and a per-cycle protocol/scoreboard compare process.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int WP = 2;

  logic          clock;
  logic          resetN;
  logic          videoReadRequest;
  logic [AW-1:0] videoReadAddress;
  logic [DW-1:0] videoReadData;
  logic          videoReadValid;
  logic          videoOverrun;
  logic          memoryWriteRequest;
  logic [AW-1:0] memoryWriteAddress;
  logic [DW-1:0] memoryWriteData;
  logic          memoryWriteComplete;
  logic [AW-1:0] memoryReadAddress;
  logic [DW-1:0] memoryReadData;
  logic [AW-1:0] sramAddress;
  logic [DW-1:0] sramDataOut;
  logic          sramDataOutEnable;
  logic [DW-1:0] sramDataIn;
  logic          sramChipEnableN;
  logic          sramOutputEnableN;
  logic          sramWriteEnableN;

  vram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT_STATES(1), .WRITE_PULSE_CYCLES(WP)
  ) dut (
    .clock(clock), .resetN(resetN),
    .videoReadRequest(videoReadRequest), .videoReadAddress(videoReadAddress),
    .videoReadData(videoReadData), .videoReadValid(videoReadValid), .videoOverrun(videoOverrun),
    .memoryWriteRequest(memoryWriteRequest), .memoryWriteAddress(memoryWriteAddress),
    .memoryWriteData(memoryWriteData), .memoryWriteComplete(memoryWriteComplete),
    .memoryReadAddress(memoryReadAddress), .memoryReadData(memoryReadData),
    .sramAddress(sramAddress), .sramDataOut(sramDataOut), .sramDataOutEnable(sramDataOutEnable),
    .sramDataIn(sramDataIn), .sramChipEnableN(sramChipEnableN),
    .sramOutputEnableN(sramOutputEnableN), .sramWriteEnableN(sramWriteEnableN)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- SRAM pin model and reference memory ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr;
  logic [DW-1:0] preload_data;

  assign sramDataIn = (!sramChipEnableN && !sramOutputEnableN) ? sram_mem[sramAddress] : '0;

  always @(posedge clock) begin
    if (preload_en) sram_mem[preload_addr] <= preload_data;
    if (!sramChipEnableN && !sramWriteEnableN && sramDataOutEnable) sram_mem[sramAddress] <= sramDataOut;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int valid_count = 0;
  int complete_count = 0;
  int overrun_count = 0;
  int last_valid_cyc = 0;
  int last_complete_cyc = 0;
  int last_doe_cyc = -100;
  int we_run = 0;
  logic [DW-1:0] last_valid_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (resetN) begin
      check("oe_with_data_drive", 32'(!sramOutputEnableN && sramDataOutEnable), 32'd0);
      check("oe_with_we", 32'(!sramOutputEnableN && !sramWriteEnableN), 32'd0);
      if (sramDataOutEnable) last_doe_cyc = cyc;
      if (!sramOutputEnableN) check("write_read_turnaround", 32'((cyc - last_doe_cyc) >= 2), 32'd1);
      if (!sramWriteEnableN) we_run++;
      if (memoryWriteComplete) begin
        check("we_pulse_length", 32'(we_run), 32'(WP));
        we_run = 0;
        complete_count++;
        last_complete_cyc = cyc;
      end
      if (videoOverrun) overrun_count++;
      if (videoReadValid) begin
        valid_count++;
        last_valid_cyc = cyc;
        last_valid_data = videoReadData;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL video_unexpected actual=0x%0h required=no_pulse", videoReadData);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (videoReadData !== e) begin
            errors++;
            $display("FAIL video_data actual=0x%0h required=0x%0h", videoReadData, e);
          end
        end
      end
    end else begin
      we_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ref_mem[addr] = data;
    preload_addr  = addr;
    preload_data  = data;
    preload_en    = 1'b1;
    @(posedge clock); #1;
    preload_en    = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ce_n", 32'(sramChipEnableN), 32'd1);
    check("rst_oe_n", 32'(sramOutputEnableN), 32'd1);
    check("rst_we_n", 32'(sramWriteEnableN), 32'd1);
    check("rst_doe", 32'(sramDataOutEnable), 32'd0);
    check("rst_addr", 32'(sramAddress), 32'd0);
    check("rst_vvalid", 32'(videoReadValid), 32'd0);
    check("rst_overrun", 32'(videoOverrun), 32'd0);
    check("rst_complete", 32'(memoryWriteComplete), 32'd0);
    check("rst_vdata", 32'(videoReadData), 32'd0);
    check("rst_mdata", 32'(memoryReadData), 32'd0);
  endtask

  task automatic video_fetch(input logic [AW-1:0] addr, input int exact_lat);
    int s;
    int v0;
    bit seen;
    @(posedge clock); #1;
    videoReadAddress = addr;
    videoReadRequest = 1'b1;
    exp_q.push_back(ref_mem[addr]);
    s  = cyc;
    v0 = valid_count;
    @(posedge clock); #1;
    videoReadRequest = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock); #1;
      if (valid_count != v0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL video_timeout addr=0x%0h actual=no_valid required=valid_within_16", addr);
    end else if (exact_lat >= 0) begin
      check("video_latency", 32'(last_valid_cyc - (s + 1)), 32'(exact_lat));
    end else begin
      check("video_latency_bound", 32'((last_valid_cyc - (s + 1)) <= 7), 32'd1);
    end
  endtask

  task automatic mcu_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int exact_lat);
    int t0;
    int c0;
    bit seen;
    @(posedge clock); #1;
    ref_mem[addr]      = data;
    memoryWriteAddress = addr;
    memoryWriteData    = data;
    memoryWriteRequest = 1'b1;
    t0 = cyc;
    c0 = complete_count;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock); #1;
      if (complete_count != c0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL write_timeout addr=0x%0h actual=no_complete required=complete_within_16", addr);
    end else if (exact_lat >= 0) begin
      check("write_latency", 32'(last_complete_cyc - t0), 32'(exact_lat));
    end
    @(posedge clock); #1;
    memoryWriteRequest = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v0;
    int c0;
    int o0;
    resetN             = 1'b0;
    videoReadRequest   = 1'b0;
    videoReadAddress   = '0;
    memoryWriteRequest = 1'b0;
    memoryWriteAddress = '0;
    memoryWriteData    = '0;
    memoryReadAddress  = '0;

    preload(17'h00123, 8'hA5);
    preload(17'h00010, 8'h77);
    preload(17'h00100, 8'h11);
    preload(17'h00200, 8'h22);
    preload(17'h00300, 8'h5A);
    check_reset_outputs();
    resetN = 1'b1;
    tick(6);

    // Video fetch: valid exactly three cycles after the request edge.
    v0 = valid_count;
    video_fetch(17'h00123, 3);
    tick(4);
    check("video_single_pulse", 32'(valid_count - v0), 32'd1);
    check("video_data_literal", 32'(last_valid_data), 32'hA5);

    // Plain write at the top address.
    c0 = complete_count;
    mcu_write(17'h1FFFF, 8'h3C, 4);
    tick(6);
    check("write_single_complete", 32'(complete_count - c0), 32'd1);
    check("write_sram_content", 32'(sram_mem[17'h1FFFF]), 32'h3C);

    // Contention: video arrives one cycle into a write.
    fork
      mcu_write(17'h00400, 8'h99, -1);
      begin
        @(posedge clock); #1;
        video_fetch(17'h00300, -1);
      end
    join
    check("write_before_video", 32'(last_complete_cyc < last_valid_cyc), 32'd1);
    check("contention_sram_content", 32'(sram_mem[17'h00400]), 32'h99);
    tick(4);

    // Read-back refresh on address change, then on write to the cached address.
    memoryReadAddress = 17'h00010;
    tick(6);
    check("readback_initial", 32'(memoryReadData), 32'h77);
    mcu_write(17'h00010, 8'h88, 4);
    tick(6);
    check("readback_after_write", 32'(memoryReadData), 32'h88);

    // Overrun: second request one cycle later replaces the first.
    v0 = valid_count;
    o0 = overrun_count;
    @(posedge clock); #1;
    videoReadAddress = 17'h00100;
    videoReadRequest = 1'b1;
    @(posedge clock); #1;
    videoReadAddress = 17'h00200;
    exp_q.push_back(ref_mem[17'h00200]);
    @(posedge clock); #1;
    videoReadRequest = 1'b0;
    tick(10);
    check("overrun_once", 32'(overrun_count - o0), 32'd1);
    check("overrun_single_valid", 32'(valid_count - v0), 32'd1);
    check("overrun_data_literal", 32'(last_valid_data), 32'h22);

    // Reset during the write pulse aborts without completion.
    @(posedge clock); #1;
    memoryWriteAddress = 17'h00555;
    memoryWriteData    = 8'hEE;
    memoryWriteRequest = 1'b1;
    tick(2);
    check("we_low_before_reset", 32'(sramWriteEnableN), 32'd0);
    c0 = complete_count;
    resetN             = 1'b0;
    memoryWriteRequest = 1'b0;
    tick(1);
    check_reset_outputs();
    tick(1);
    resetN = 1'b1;
    tick(8);
    check("no_complete_after_abort", 32'(complete_count - c0), 32'd0);
    check("video_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the single-port external video SRAM and shares it between three requesters: scanout pixel fetch (video), MCU write port, and MCU read-back port.
- Sits between the video timing/scanout logic, the MCU register interface and the SRAM pins.
- Owns all SRAM control strobes.
- Video has strict priority because it is hard real-time.

Parameters:
- ADDR_WIDTH, 17, SRAM/pixel address width.
- DATA_WIDTH, 8, SRAM data width.
- READ_WAIT_STATES, 1, extra cycles the address/OE is held before read data is captured (0..3).
- WRITE_PULSE_CYCLES, 2, cycles WE is held low per write (1..4).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetN  in  1  synchronous, active-low reset.
- videoReadRequest  in  1  one-cycle pulse requesting a fetch at videoReadAddress.
- videoReadAddress  in  ADDR_WIDTH  fetch address, sampled with videoReadRequest.
- videoReadData  out  DATA_WIDTH  fetched byte, valid with videoReadValid.
- videoReadValid  out  1  one-cycle pulse.
- videoOverrun  out  1  one-cycle pulse: a video request arrived while one was still pending.
- memoryWriteRequest  in  1  level; held high until memoryWriteComplete is seen.
- memoryWriteAddress  in  ADDR_WIDTH  write address, stable while request is high.
- memoryWriteData  in  DATA_WIDTH  write data, stable while request is high.
- memoryWriteComplete  out  1  one-cycle pulse ending a write.
- memoryReadAddress  in  ADDR_WIDTH  continuous MCU read-back address.
- memoryReadData  out  DATA_WIDTH  SRAM contents at the last refreshed read-back address.
- sramAddress  out  ADDR_WIDTH  SRAM address pins.
- sramDataOut  out  DATA_WIDTH  write data to pad.
- sramDataOutEnable  out  1  pad output enable.
- sramDataIn  in  DATA_WIDTH  read data from pad.
- sramChipEnableN  out  1  SRAM chip enable, active low.
- sramOutputEnableN  out  1  SRAM output enable, active low.
- sramWriteEnableN  out  1  SRAM write enable, active low.

Behaviour:
- Reset (resetN low at an edge):
  - state IDLE; sramChipEnableN/OutputEnableN/WriteEnableN = 1.
  - sramDataOutEnable = 0; sramAddress = 0.
  - videoReadValid, videoOverrun, memoryWriteComplete = 0; videoReadData, memoryReadData = 0.
  - video pending cleared; read-back cache address = 0 and marked stale.
  - A write or read in progress is aborted with no completion pulse.
- Video pending register:
  - videoReadRequest latches the address and sets pending.
  - If pending is already set, or the latched request has not yet entered VREAD: the new address overwrites it and videoOverrun pulses the next cycle.
- Read-back stale flag is set when any of these occur:
  - memoryReadAddress differs from the cached address;
  - a write completes to the cached address;
  - after reset.
- Arbitration in IDLE, evaluated every cycle, priority order:
  1. video pending -> VREAD;
  2. memoryWriteRequest high and not in the cooldown cycle -> WSETUP;
  3. read-back stale -> RREAD;
  4. otherwise stay IDLE.
- Cooldown: the cycle immediately after memoryWriteComplete; a write request is ignored in that cycle only.
- No preemption: an operation, once started, always completes.
- VREAD:
  - sramAddress = pending address; CE_N = 0, OE_N = 0, for 1+READ_WAIT_STATES cycles.
  - sramDataIn is captured at the final edge.
  - videoReadData updates and videoReadValid pulses the following cycle; pending clears on entry.
- WSETUP, 1 cycle: address and data driven, sramDataOutEnable = 1, CE_N = 0, WE_N = 1.
- WPULSE, WRITE_PULSE_CYCLES cycles: WE_N = 0.
- WHOLD, 1 cycle: WE_N = 1, data still driven; memoryWriteComplete pulses during this cycle; return to IDLE.
- RREAD:
  - Same timing as VREAD, using memoryReadAddress sampled on entry (stored as the cached address).
  - memoryReadData updates the cycle after capture; stale clears unless the address changed meanwhile.
- OE_N and sramDataOutEnable are never both active; at least one IDLE/turnaround cycle separates any write from a following read.
- Latency at defaults, with IDLE and no contention:
  - request edge T -> VREAD T+1..T+2 -> videoReadValid at T+3.
  - Write request seen at T -> complete at T+4.
- Worst-case video latency = 3 + write length (4) = 7 cycles; the video requester spaces its fetches accordingly.
- Addresses are used as-is (no wrap arithmetic inside the block).

Test Plan:
- Video fetch: reset, preload SRAM model addr 0x00123 = 0xA5, pulse videoReadRequest addr 0x00123 at T -> videoReadValid=1 and videoReadData=0xA5 at T+3, exactly one pulse.
- Write: request addr 0x1FFFF data 0x3C -> WE_N low 2 cycles, complete pulse once at T+4; model holds 0x3C; request dropped next cycle, no second write.
- Contention: write enters WSETUP, video request one cycle later -> write completes first, then VREAD; videoReadValid within 7 cycles; no OE_N/WE_N overlap.
- Read-back: memoryReadAddress=0x00010 (model 0x77) -> memoryReadData=0x77; then write 0x88 to 0x00010 -> memoryReadData becomes 0x88 without an address change.
- Overrun: two video pulses 1 cycle apart (0x100, 0x200) -> videoOverrun pulses once; single videoReadValid returning data at 0x200.
- Reset mid-write: assert resetN low during WPULSE -> next edge WE_N=1, CE_N=1, no memoryWriteComplete; all outputs at reset values.
